pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Sequential control-flow controller between the instruction decoder and the PC register. Accepts one decoded branch/jump per issue and evaluates it against the ALU status flags. Resolves the target and drives a single-cycle PC load. For memory-addressed jumps (jrs, jmsub) it runs a request/acknowledge read of the target word from data memory, stalling the front end until the target is known.

## Interface
Parameters:
- ADDR_W, 32, width of PC, offsets, register values and memory addresses

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- issue  in  1  decoded control-flow instruction valid this cycle; accepted only while busy=0
- jmsub, jrs, balrn, bneal, beq  in  1 each  one-hot instruction class; all 0 with issue=1 means not taken
- status  in  2  [1]=zero, [0]=negative, valid in the issue cycle
- pc  in  ADDR_W  PC of the issuing instruction
- br_off  in  ADDR_W  sign-extended byte offset, already shifted
- rs_val  in  ADDR_W  register operand; memory pointer for jrs/jmsub, target for balrn
- mem_ack  in  1  memory read complete; mem_rdata valid this cycle
- mem_rdata  in  ADDR_W  target word returned by memory
- busy  out  1  controller not IDLE; upstream holds issue
- pc_load  out  1  one-cycle pulse: PC <= pc_target
- pc_sel  out  2  source code registered with pc_load: 00 seq, 01 PC-relative, 10 memory, 11 register
- pc_target  out  ADDR_W  redirect address
- mem_req  out  1  read request, held until acknowledged
- mem_addr  out  ADDR_W  read address (captured rs_val)
- link_we  out  1  return-address write pulse (LINK_EN only)
- link_data  out  ADDR_W  return address pc+4 (LINK_EN only)

## Operation
- States: IDLE, MEM_WAIT, REDIRECT.
- Decode priority in the issue cycle, highest first:
  - (bneal & ~zero) | (beq & zero) → PC-relative, target = pc + 4 + br_off
  - jrs | jmsub → memory
  - balrn & negative → register, target = rs_val
  - otherwise not taken
- IDLE + issue, PC-relative or register: capture target, sel and link decision; go to REDIRECT.
- IDLE + issue, memory: capture mem_addr = rs_val; go to MEM_WAIT.
- IDLE + issue, not taken: stay in IDLE; no outputs change.
- MEM_WAIT: mem_req=1. On mem_ack, capture mem_rdata as target with sel=10, then go to REDIRECT.
- REDIRECT: pc_load=1 for exactly one cycle (plus link_we if linking), then go to IDLE.
- Linking instructions: bneal when taken, balrn when taken, jmsub always. jrs and beq never link.
- Arithmetic: modulo 2^ADDR_W, wrap silently. pc_target[1:0] forced to 00 on every path.
- issue while busy=1 is ignored.
- mem_ack outside MEM_WAIT is ignored.
- reset in any state: go to IDLE, drop mem_req, clear captured state; a later ack for the aborted read is ignored.

## Timing
- Reset values: busy=0, pc_load=0, pc_sel=00, pc_target=0, mem_req=0, mem_addr=0, link_we=0, link_data=0.
- busy = (state != IDLE), registered.
- Direct path: issue at cycle T → pc_load at T+1, busy=1 at T+1 only, IDLE at T+2. Next issue is accepted at T+2.
- Memory path: issue at T → mem_req rises at T+1. With mem_ack first sampled high at cycle A ≥ T+1: mem_req falls at A+1, pc_load at A+1, IDLE at A+2. Minimum latency is 2 cycles.
- pc_sel, pc_target and link_data are stable for the whole pc_load cycle and hold their value afterwards until the next capture.

## Configuration
- PC_REDIRECT_LINK_EN defined: link_we pulses coincident with pc_load for linking instructions, with link_data = pc + 4 captured at issue.
- PC_REDIRECT_LINK_EN undefined: link_we tied 0, link_data tied 0, no link capture registers; redirects are unchanged.

## Test plan
- beq, zero=1, pc=0x100, br_off=0x20 → pc_load at T+1, pc_sel=01, pc_target=0x124, busy=1 one cycle.
- bneal, zero=0, pc=0x200, br_off=0xFFFFFFF0, LINK_EN → pc_target=0x1F4, link_we=1, link_data=0x204. Same stimulus with zero=1 → no pc_load, no link, busy stays 0.
- jmsub, rs_val=0x400, mem_ack after 3 cycles with mem_rdata=0x1003 → mem_addr=0x400, mem_req held 3 cycles, pc_load the cycle after ack, pc_sel=10, pc_target=0x1000, link_we=1.
- balrn with negative=1, rs_val=0x800, and beq=1 zero=1 asserted simultaneously → PC-relative wins, pc_sel=01. balrn alone with negative=0 → not taken.
- jrs, reset asserted while in MEM_WAIT, mem_ack 2 cycles later → mem_req=0 the cycle after reset, no pc_load, busy=0.
- pc=0xFFFFFFFC, beq taken, br_off=0x8 → pc_target=0x00000008 (wrap).

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Control-flow redirect controller: decodes one branch/jump per issue and drives a one-cycle PC load.
// Optional PC_REDIRECT_LINK_EN adds a return-address (pc+4) write pulse alongside the load.
module pc_redirect_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic              jmsub,
    input  logic              jrs,
    input  logic              balrn,
    input  logic              bneal,
    input  logic              beq,
    input  logic [1:0]        status,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] br_off,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              busy,
    output logic              pc_load,
    output logic [1:0]        pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_data
);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, REDIRECT} state_t;

    state_t state;

    logic zero;
    logic neg;
    logic take_rel;
    logic take_mem;
    logic take_reg;
    logic signed [ADDR_W-1:0] off_s;
    logic [ADDR_W-1:0] rel_target;

    // Instruction fetch is word aligned, so every redirect target drops its low two bits.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    assign zero       = status[1];
    assign neg        = status[0];
    assign take_rel   = (bneal & ~zero) | (beq & zero);
    assign take_mem   = ~take_rel & (jrs | jmsub);
    assign take_reg   = ~take_rel & ~take_mem & balrn & neg;
    assign off_s      = br_off;
    assign rel_target = pc + ADDR_W'(4) + $unsigned(off_s);

`ifdef PC_REDIRECT_LINK_EN
    logic link_dec;
    logic link_pend;

    assign link_dec = take_rel ? (bneal & ~zero) : (take_mem ? jmsub : take_reg);
`else
    assign link_we   = 1'b0;
    assign link_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pc_load   <= 1'b0;
            pc_sel    <= 2'b00;
            pc_target <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
`ifdef PC_REDIRECT_LINK_EN
            link_we   <= 1'b0;
            link_data <= '0;
            link_pend <= 1'b0;
`endif
        end else begin
            pc_load <= 1'b0;
`ifdef PC_REDIRECT_LINK_EN
            link_we <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // A not-taken issue leaves every output untouched.
                    if (issue && (take_rel || take_mem || take_reg)) begin
                        busy <= 1'b1;
`ifdef PC_REDIRECT_LINK_EN
                        link_pend <= link_dec;
                        if (link_dec) begin
                            link_data <= pc + ADDR_W'(4);
                        end
`endif
                        if (take_mem) begin
                            mem_addr <= rs_val;
                            mem_req  <= 1'b1;
                            state    <= MEM_WAIT;
                        end else begin
                            pc_target <= word_align(take_rel ? rel_target : rs_val);
                            pc_sel    <= take_rel ? 2'b01 : 2'b11;
                            pc_load   <= 1'b1;
`ifdef PC_REDIRECT_LINK_EN
                            link_we   <= link_dec;
`endif
                            state     <= REDIRECT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        pc_target <= word_align(mem_rdata);
                        pc_sel    <= 2'b10;
                        pc_load   <= 1'b1;
`ifdef PC_REDIRECT_LINK_EN
                        link_we   <= link_pend;
`endif
                        state     <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: cycle-level reference model plus directed vectors with literal expectations.
module tb_pc_redirect_ctrl;

`ifdef PC_REDIRECT_LINK_EN
    localparam bit LINK_EN = 1'b1;
`else
    localparam bit LINK_EN = 1'b0;
`endif

    localparam logic [4:0] C_JMSUB = 5'b10000;
    localparam logic [4:0] C_JRS   = 5'b01000;
    localparam logic [4:0] C_BALRN = 5'b00100;
    localparam logic [4:0] C_BNEAL = 5'b00010;
    localparam logic [4:0] C_BEQ   = 5'b00001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue = 1'b0;
    logic        jmsub = 1'b0, jrs = 1'b0, balrn = 1'b0, bneal = 1'b0, beq = 1'b0;
    logic [1:0]  status = 2'b00;
    logic [31:0] pc = '0, br_off = '0, rs_val = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy, pc_load, mem_req, link_we;
    logic [1:0]  pc_sel;
    logic [31:0] pc_target, mem_addr, link_data;

    int tests = 0;
    int fails = 0;

    pc_redirect_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .issue(issue),
        .jmsub(jmsub), .jrs(jrs), .balrn(balrn), .bneal(bneal), .beq(beq),
        .status(status), .pc(pc), .br_off(br_off), .rs_val(rs_val),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .pc_load(pc_load), .pc_sel(pc_sel), .pc_target(pc_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .link_we(link_we), .link_data(link_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: expected outputs derived from the instruction rules.
    // busy is simply "a memory read is outstanding, or this is the load cycle".
    logic        e_busy = 1'b0, e_load = 1'b0, e_req = 1'b0, e_lwe = 1'b0;
    logic [1:0]  e_sel = 2'b00;
    logic [31:0] e_target = '0, e_maddr = '0, e_ldata = '0;
    bit          waiting = 1'b0, link_pend = 1'b0, model_ok = 1'b0;

    always @(posedge clk) begin
        bit z, n, was_busy, lnk;
        if (reset) begin
            e_busy = 0; e_load = 0; e_req = 0; e_lwe = 0; e_sel = 0;
            e_target = 0; e_maddr = 0; e_ldata = 0;
            waiting = 0; link_pend = 0; model_ok = 1;
        end else begin
            was_busy = e_busy;
            e_load = 0;
            e_lwe = 0;
            z = status[1];
            n = status[0];
            if (waiting) begin
                if (mem_ack) begin
                    e_target = mem_rdata & ~32'h3;
                    e_sel = 2'b10;
                    e_load = 1;
                    e_lwe = LINK_EN && link_pend;
                    e_req = 0;
                    waiting = 0;
                end
            end else if (!was_busy && issue) begin
                lnk = 0;
                if ((bneal && !z) || (beq && z)) begin
                    e_target = (pc + 32'd4 + br_off) & ~32'h3;
                    e_sel = 2'b01;
                    e_load = 1;
                    lnk = bneal && !z;
                    e_lwe = LINK_EN && lnk;
                end else if (jrs || jmsub) begin
                    e_maddr = rs_val;
                    e_req = 1;
                    waiting = 1;
                    lnk = jmsub;
                    link_pend = lnk;
                end else if (balrn && n) begin
                    e_target = rs_val & ~32'h3;
                    e_sel = 2'b11;
                    e_load = 1;
                    lnk = 1;
                    e_lwe = LINK_EN;
                end
                if (LINK_EN && lnk) e_ldata = pc + 32'd4;
            end
            e_busy = waiting || e_load;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("cmp_busy", 32'(busy), 32'(e_busy));
            chk("cmp_pc_load", 32'(pc_load), 32'(e_load));
            chk("cmp_pc_sel", 32'(pc_sel), 32'(e_sel));
            chk("cmp_pc_target", pc_target, e_target);
            chk("cmp_mem_req", 32'(mem_req), 32'(e_req));
            chk("cmp_mem_addr", mem_addr, e_maddr);
            chk("cmp_link_we", 32'(link_we), 32'(e_lwe));
            chk("cmp_link_data", link_data, e_ldata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] cls, input logic [1:0] st,
                          input logic [31:0] p, input logic [31:0] off, input logic [31:0] rs);
        issue = 1'b1;
        {jmsub, jrs, balrn, bneal, beq} = cls;
        status = st;
        pc = p;
        br_off = off;
        rs_val = rs;
    endtask

    task automatic clr();
        issue = 1'b0;
        {jmsub, jrs, balrn, bneal, beq} = 5'b0;
        status = 2'b00;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_target", pc_target, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        tick();

        // beq taken, PC-relative
        set_in(C_BEQ, 2'b10, 32'h100, 32'h20, 32'h0);
        tick(); clr();
        @(negedge clk);
        chk("beq_load", 32'(pc_load), 32'h1);
        chk("beq_sel", 32'(pc_sel), 32'h1);
        chk("beq_target", pc_target, 32'h124);
        chk("beq_busy", 32'(busy), 32'h1);
        tick();
        @(negedge clk);
        chk("beq_busy_drop", 32'(busy), 32'h0);
        tick();

        // bneal taken with negative offset, then the same with zero=1
        set_in(C_BNEAL, 2'b00, 32'h200, 32'hFFFF_FFF0, 32'h0);
        tick(); clr();
        @(negedge clk);
        chk("bneal_target", pc_target, 32'h1F4);
        chk("bneal_link_we", 32'(link_we), 32'(LINK_EN));
        chk("bneal_link_data", link_data, LINK_EN ? 32'h204 : 32'h0);
        tick();
        set_in(C_BNEAL, 2'b10, 32'h200, 32'hFFFF_FFF0, 32'h0);
        tick(); clr();
        @(negedge clk);
        chk("bneal_nt_load", 32'(pc_load), 32'h0);
        chk("bneal_nt_busy", 32'(busy), 32'h0);
        chk("bneal_nt_hold", pc_target, 32'h1F4);
        tick();

        // jmsub through memory, ack in the third request cycle
        set_in(C_JMSUB, 2'b00, 32'h600, 32'h0, 32'h400);
        tick(); clr();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("jmsub_req", 32'(mem_req), 32'h1);
            chk("jmsub_addr", mem_addr, 32'h400);
            chk("jmsub_noload", 32'(pc_load), 32'h0);
            if (i == 2) begin
                mem_ack = 1'b1;
                mem_rdata = 32'h1003;
            end
            tick();
        end
        mem_ack = 1'b0;
        @(negedge clk);
        chk("jmsub_load", 32'(pc_load), 32'h1);
        chk("jmsub_sel", 32'(pc_sel), 32'h2);
        chk("jmsub_target", pc_target, 32'h1000);
        chk("jmsub_req_drop", 32'(mem_req), 32'h0);
        chk("jmsub_link_we", 32'(link_we), 32'(LINK_EN));
        chk("jmsub_link_data", link_data, LINK_EN ? 32'h604 : 32'h0);
        tick();

        // PC-relative beats register; balrn not taken; balrn taken alone
        set_in(C_BALRN | C_BEQ, 2'b11, 32'h300, 32'h10, 32'h800);
        tick(); clr();
        @(negedge clk);
        chk("prio_sel", 32'(pc_sel), 32'h1);
        chk("prio_target", pc_target, 32'h314);
        chk("prio_link_we", 32'(link_we), 32'h0);
        tick();
        set_in(C_BALRN, 2'b00, 32'h300, 32'h10, 32'h800);
        tick(); clr();
        @(negedge clk);
        chk("balrn_nt_load", 32'(pc_load), 32'h0);
        chk("balrn_nt_busy", 32'(busy), 32'h0);
        tick();
        set_in(C_BALRN, 2'b01, 32'h340, 32'h0, 32'h803);
        tick(); clr();
        @(negedge clk);
        chk("balrn_sel", 32'(pc_sel), 32'h3);
        chk("balrn_target", pc_target, 32'h800);
        chk("balrn_link_data", link_data, LINK_EN ? 32'h344 : 32'h0);
        tick();

        // jrs aborted by reset; a late ack must be ignored
        set_in(C_JRS, 2'b00, 32'h700, 32'h0, 32'h500);
        tick(); clr();
        @(negedge clk);
        chk("jrs_req", 32'(mem_req), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_req", 32'(mem_req), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_target", pc_target, 32'h0);
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'h9000;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_load", 32'(pc_load), 32'h0);
        chk("late_ack_busy", 32'(busy), 32'h0);
        tick();

        // address wrap
        set_in(C_BEQ, 2'b10, 32'hFFFF_FFFC, 32'h8, 32'h0);
        tick(); clr();
        @(negedge clk);
        chk("wrap_target", pc_target, 32'h8);
        chk("wrap_sel", 32'(pc_sel), 32'h1);
        tick();

        // issue while busy is ignored
        set_in(C_BEQ, 2'b10, 32'h1000, 32'h0, 32'h0);
        tick();
        set_in(C_BNEAL, 2'b00, 32'h2000, 32'h40, 32'h0);
        tick(); clr();
        @(negedge clk);
        chk("busy_ign_load", 32'(pc_load), 32'h0);
        chk("busy_ign_target", pc_target, 32'h1004);
        tick();

        // stray ack in IDLE
        mem_ack = 1'b1;
        mem_rdata = 32'hABC0;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_load", 32'(pc_load), 32'h0);
        chk("stray_ack_target", pc_target, 32'h1004);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
